// File: rtl/stage_pkg.sv
// Shared constants for the stage-fall animation blocks.
// State encoding, stage geometry and default tick divider.
package stage_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_GEN  = 3'd1;
    localparam logic [2:0] S_UPD  = 3'd2;
    localparam logic [2:0] S_FALL = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [9:0] STAGE_Y_REST = 10'd500;
    localparam logic [9:0] STAGE_Y_TOP  = 10'd0;
    localparam logic [9:0] STAGE_STEP   = 10'd5;

    localparam logic [19:0] PULSE_DIV_DEF = 20'd500000;

endpackage

// File: rtl/pulse_div.sv
// Clearable free-running divider; tick is a registered
// one-cycle strobe issued after DIV enabled cycles.
module pulse_div #(
    parameter int unsigned    W   = 20,
    parameter logic [W-1:0]   DIV = 20'd500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [W-1:0] LAST = DIV - {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/stage_fall_ctrl.sv
// Initiator-side sequencer for the stage-fall responder:
// command strobes, animation ticks and a fall watchdog.
module stage_fall_ctrl
    import stage_pkg::*;
#(
    parameter int unsigned       DIV_W          = 20,
    parameter logic [DIV_W-1:0]  PULSE_DIV      = PULSE_DIV_DEF,
    parameter int unsigned       TO_W           = 8,
    parameter logic [TO_W-1:0]   TIMEOUT_PULSES = 8'd127
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic restart,
    input  logic fall_fin,
    output logic generate_en,
    output logic update,
    output logic enable,
    output logic pulse,
    output logic busy,
    output logic done,
    output logic timeout_err
);

    logic [2:0]      state_q, state_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            gen_q, upd_q, en_q, busy_q, done_q;
    logic            terr_q, terr_d;
    logic            tick, div_en, div_clr;

    // Watchdog counts ticks as they are shown, so wd_d already
    // includes the pulse visible in this cycle.
    always_comb begin
        wd_d = wd_q;
        if (state_q == S_UPD) begin
            wd_d = '0;
        end else if (tick && wd_q != TIMEOUT_PULSES) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = S_GEN;
        end else begin
            case (state_q)
                S_IDLE: if (start) state_d = S_UPD;
                S_UPD:  state_d = S_FALL;
                S_FALL: begin
                    if (fall_fin) begin
                        state_d = S_FIN;
                    end else if (wd_d == TIMEOUT_PULSES) begin
                        state_d = S_ERR;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        terr_d = terr_q;
        if (state_d == S_ERR) begin
            terr_d = 1'b1;
        end else if (state_d == S_GEN) begin
            terr_d = 1'b0;
        end
    end

    // A tick is only issued on edges that keep us in FALL, so
    // pulse can never outlive enable.
    assign div_en  = (state_q == S_FALL) && (state_d == S_FALL);
    assign div_clr = (state_q == S_UPD);

    pulse_div #(
        .W   (DIV_W),
        .DIV (PULSE_DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (div_clr),
        .en   (div_en),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wd_q    <= '0;
            gen_q   <= 1'b0;
            upd_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            gen_q   <= (state_d == S_GEN);
            upd_q   <= (state_d == S_UPD);
            en_q    <= (state_d == S_FALL);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_FIN);
            terr_q  <= terr_d;
        end
    end

    assign generate_en = gen_q;
    assign update      = upd_q;
    assign enable      = en_q;
    assign pulse       = tick;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_stage_fall_ctrl.sv
// Bench for stage_fall_ctrl: directed scenarios plus random
// stimulus against a cycle-count behavioural model.
module tb_stage_fall_ctrl;

    localparam int PD = 4;
    localparam int TO = 8;

    logic clk, rst, start, restart, fall_fin;
    logic generate_en, update, enable, pulse, busy, done, timeout_err;

    int tests = 0;
    int fails = 0;

    stage_fall_ctrl #(
        .DIV_W          (20),
        .PULSE_DIV      (20'd4),
        .TO_W           (8),
        .TIMEOUT_PULSES (8'd8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .restart     (restart),
        .fall_fin    (fall_fin),
        .generate_en (generate_en),
        .update      (update),
        .enable      (enable),
        .pulse       (pulse),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase plus cycles spent falling.
    typedef enum {M_IDLE, M_GEN, M_UPD, M_FALL, M_FIN, M_ERR} mph_t;
    mph_t ph = M_IDLE;
    int   ft = 0;
    bit   terr = 0;
    bit   mvalid = 0;

    always @(posedge clk) begin
        if (!rst) begin
            ph = M_IDLE; ft = 0; terr = 0; mvalid = 1;
        end else if (mvalid) begin
            if (restart) begin
                ph = M_GEN; terr = 0;
            end else begin
                case (ph)
                    M_IDLE: if (start) ph = M_UPD;
                    M_UPD: begin ph = M_FALL; ft = 1; end
                    M_FALL: begin
                        if (fall_fin) ph = M_FIN;
                        else if ((ft - 1) / PD == TO) begin
                            ph = M_ERR; terr = 1;
                        end else ft++;
                    end
                    default: ph = M_IDLE;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        logic exp_p;
        logic [6:0] exp_v, act_v;
        if (mvalid) begin
            exp_p = (ph == M_FALL) && ft > 1 && ((ft - 1) % PD) == 0;
            exp_v = {ph == M_GEN, ph == M_UPD, ph == M_FALL, exp_p,
                     ph != M_IDLE, ph == M_FIN, terr};
            act_v = {generate_en, update, enable, pulse, busy, done, timeout_err};
            check("model_outputs", 32'(act_v), 32'(exp_v));
            check("onehot_gen_upd_en",
                  32'($countones({generate_en, update, enable}) <= 1), 1);
            check("pulse_implies_en", 32'(!pulse || enable), 1);
        end
    end

    // Responder model: raise fall_fin one cycle after its Nth pulse.
    int resp_n = 0, resp_cnt = 0;
    bit rand_resp = 0, fin_pending = 0, force_fin = 0;

    always @(negedge clk) begin
        if (update === 1'b1) begin
            resp_cnt = 0;
            if (rand_resp) resp_n = $urandom_range(0, 10);
        end else if (pulse === 1'b1 && resp_n != 0) begin
            resp_cnt++;
            if (resp_cnt == resp_n) fin_pending = 1;
        end
    end

    always @(posedge clk) begin
        #1;
        fall_fin = fin_pending | force_fin;
        fin_pending = 0;
    end

    initial begin
        logic [19:0] upd_m, en_m, pul_m, done_m;
        int np, nu, nd, ng;
        rst = 0; start = 0; restart = 0; fall_fin = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_after_reset",
                  32'({generate_en, update, enable, pulse, busy, done, timeout_err}), 0);
        end

        // Normal fall, responder finishes after 3 pulses.
        resp_n = 3;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        upd_m = '0; en_m = '0; pul_m = '0; done_m = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            upd_m[i] = update; en_m[i] = enable;
            pul_m[i] = pulse; done_m[i] = done;
        end
        check("fall_update_win", 32'(upd_m), 32'h00001);
        check("fall_enable_win", 32'(en_m), 32'h07FFE);
        check("fall_pulse_win", 32'(pul_m), 32'h02220);
        check("fall_done_win", 32'(done_m), 32'h08000);

        // Restart after two pulses.
        resp_n = 0;
        repeat (3) @(posedge clk);
        #1 start = 1;
        @(posedge clk); #1 start = 0;
        np = 0;
        for (int i = 0; i < 40 && np < 2; i++) begin
            @(negedge clk);
            if (pulse) np++;
        end
        check("restart_prepulses", np, 2);
        @(posedge clk); #1 restart = 1;
        @(posedge clk); #1 restart = 0;
        @(negedge clk);
        check("restart_gen_en_p_u", 32'({generate_en, enable, pulse, update}), 32'h8);
        @(negedge clk);
        check("restart_then_idle", 32'(busy), 0);

        // Watchdog: responder never finishes.
        repeat (2) @(posedge clk);
        #1 start = 1;
        @(posedge clk); #1 start = 0;
        np = 0;
        for (int i = 0; i < 100 && timeout_err !== 1'b1; i++) begin
            @(negedge clk);
            if (pulse) np++;
        end
        check("wd_pulse_count", np, TO);
        check("wd_err_set", 32'({timeout_err, enable, pulse}), 32'h4);
        @(negedge clk);
        check("wd_idle_sticky", 32'({busy, timeout_err}), 32'h1);
        @(posedge clk); #1 restart = 1;
        @(posedge clk); #1 restart = 0;
        @(negedge clk);
        check("wd_restart_clear", 32'({generate_en, timeout_err}), 32'h2);

        // start and restart together from IDLE.
        repeat (2) @(posedge clk);
        #1 start = 1; restart = 1;
        @(posedge clk); #1 start = 0; restart = 0;
        ng = 0; nu = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (generate_en) ng++;
            if (update) nu++;
        end
        check("both_gen_count", ng, 1);
        check("both_upd_count", nu, 0);

        // start re-pulsed during FALL is dropped.
        resp_n = 2;
        nu = 0; nd = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (update) nu++;
            if (done) nd++;
            start = (i == 0 || i == 5 || i == 8);
        end
        check("busy_start_upd", nu, 1);
        check("busy_start_done", nd, 1);

        // fall_fin while IDLE.
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
            force_fin = (i < 3);
        end
        check("idle_fin_no_done", nd, 0);

        // Random traffic.
        rand_resp = 1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #2;
            start     = ($urandom_range(0, 3) == 0);
            restart   = ($urandom_range(0, 60) == 0);
            force_fin = ($urandom_range(0, 40) == 0);
            rst       = ($urandom_range(0, 400) != 0);
        end
        #2 start = 0; restart = 0; force_fin = 0; rst = 1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
